// File: rtl/side_sensor.sv
// Side-road vehicle detector: synchronizes and debounces the inductive loop,
// counts waiting vehicles, and retires one vehicle per DEPART_CYCLES green cycles.
module side_sensor #(
    parameter int DEB_CYCLES    = 2,
    parameter int DEPART_CYCLES = 3,
    parameter int QMAX          = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       loop_raw,
    input  logic [2:0] side_road,
    output logic       SENSOR,
    output logic [7:0] queue_cnt,
    output logic       overflow
);

    localparam logic [4:0] DEB_N  = 5'(DEB_CYCLES);
    localparam logic [8:0] DEP_N  = 9'(DEPART_CYCLES);
    localparam logic [7:0] QMAX_V = 8'(QMAX);
    localparam logic [2:0] GREEN  = 3'b001;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RISE_CHK = 2'd1,
        OCCUPIED = 2'd2,
        FALL_CHK = 2'd3
    } deb_state_e;

    logic       sync1_q, loop_s_q;
    deb_state_e state_q, state_d;
    logic [3:0] deb_cnt_q, deb_cnt_d;
    logic [4:0] deb_inc;
    logic       arrival;

    logic [7:0] dep_tmr_q, dep_tmr_d;
    logic [8:0] dep_inc;
    logic       depart;

    logic [7:0] queue_q, queue_d;
    logic       sensor_q, sensor_d;
    logic       ovf_q, ovf_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            loop_s_q <= 1'b0;
        end else begin
            sync1_q  <= loop_raw;
            loop_s_q <= sync1_q;
        end
    end

    // Debounce FSM: arrival fires on the edge that accepts a stable rising loop.
    assign deb_inc = {1'b0, deb_cnt_q} + 5'd1;

    always_comb begin
        state_d   = state_q;
        deb_cnt_d = deb_cnt_q;
        arrival   = 1'b0;
        case (state_q)
            IDLE: begin
                if (loop_s_q) begin
                    if (DEB_N <= 5'd1) begin
                        state_d   = OCCUPIED;
                        deb_cnt_d = 4'd0;
                        arrival   = 1'b1;
                    end else begin
                        state_d   = RISE_CHK;
                        deb_cnt_d = 4'd1;
                    end
                end
            end
            RISE_CHK: begin
                if (!loop_s_q) begin
                    state_d   = IDLE;
                    deb_cnt_d = 4'd0;
                end else if (deb_inc >= DEB_N) begin
                    state_d   = OCCUPIED;
                    deb_cnt_d = 4'd0;
                    arrival   = 1'b1;
                end else begin
                    deb_cnt_d = deb_inc[3:0];
                end
            end
            OCCUPIED: begin
                if (!loop_s_q) begin
                    if (DEB_N <= 5'd1) begin
                        state_d   = IDLE;
                        deb_cnt_d = 4'd0;
                    end else begin
                        state_d   = FALL_CHK;
                        deb_cnt_d = 4'd1;
                    end
                end
            end
            FALL_CHK: begin
                if (loop_s_q) begin
                    state_d   = OCCUPIED;
                    deb_cnt_d = 4'd0;
                end else if (deb_inc >= DEB_N) begin
                    state_d   = IDLE;
                    deb_cnt_d = 4'd0;
                end else begin
                    deb_cnt_d = deb_inc[3:0];
                end
            end
            default: begin
                state_d   = IDLE;
                deb_cnt_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            deb_cnt_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    // Departure timer: any non-green code, legal or not, restarts the count.
    assign dep_inc = {1'b0, dep_tmr_q} + 9'd1;

    always_comb begin
        dep_tmr_d = 8'd0;
        depart    = 1'b0;
        if (side_road == GREEN) begin
            if (dep_inc >= DEP_N) begin
                depart = 1'b1;
            end else begin
                dep_tmr_d = dep_inc[7:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) dep_tmr_q <= 8'd0;
        else     dep_tmr_q <= dep_tmr_d;
    end

    // Coincident arrival and departure cancel, even at the empty/full limits.
    always_comb begin
        queue_d = queue_q;
        ovf_d   = ovf_q;
        if (arrival && !depart) begin
            if (queue_q >= QMAX_V) ovf_d = 1'b1;
            else                   queue_d = queue_q + 8'd1;
        end else if (depart && !arrival) begin
            if (queue_q != 8'd0) queue_d = queue_q - 8'd1;
        end
        sensor_d = (queue_d != 8'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            queue_q  <= 8'd0;
            sensor_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            queue_q  <= queue_d;
            sensor_q <= sensor_d;
            ovf_q    <= ovf_d;
        end
    end

    assign SENSOR    = sensor_q;
    assign queue_cnt = queue_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_side_sensor.sv
// Directed bench for side_sensor: default instance plus a QMAX=3 instance for saturation.
module tb_side_sensor;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       loop_raw = 1'b0;
    logic [2:0] side_road = 3'b100;

    logic       sensor_a, ovf_a, sensor_b, ovf_b;
    logic [7:0] q_a, q_b;

    int vectors = 0;
    int errors  = 0;

    localparam logic [2:0] RED   = 3'b100;
    localparam logic [2:0] GREEN = 3'b001;

    always #5 clk = ~clk;

    side_sensor #(.DEB_CYCLES(2), .DEPART_CYCLES(3), .QMAX(255)) dut_a (
        .clk(clk), .rst(rst), .loop_raw(loop_raw), .side_road(side_road),
        .SENSOR(sensor_a), .queue_cnt(q_a), .overflow(ovf_a)
    );

    side_sensor #(.DEB_CYCLES(2), .DEPART_CYCLES(3), .QMAX(3)) dut_b (
        .clk(clk), .rst(rst), .loop_raw(loop_raw), .side_road(side_road),
        .SENSOR(sensor_b), .queue_cnt(q_b), .overflow(ovf_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; loop_raw = 1'b0; side_road = RED;
        tick(); tick();
        rst = 1'b0;
    endtask

    // One clean vehicle: arrival lands on the 4th edge, loop settles back to idle.
    task automatic do_arrival();
        loop_raw = 1'b1;
        repeat (5) tick();
        loop_raw = 1'b0;
        repeat (6) tick();
    endtask

    task automatic test_reset();
        logic [9:0] exp;
        rst = 1'b1; loop_raw = 1'b1; side_road = GREEN;
        for (int i = 1; i <= 2; i++) begin
            tick();
            vectors++;
            if ({ovf_a, sensor_a, q_a} !== 10'd0) begin
                errors++;
                $display("FAIL reset_hold edge%0d got %h want %h", i, {ovf_a, sensor_a, q_a}, 10'd0);
            end
        end
        rst = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            tick();
            exp = (e == 4) ? {1'b0, 1'b1, 8'd1} : 10'd0;
            vectors++;
            if ({ovf_a, sensor_a, q_a} !== exp) begin
                errors++;
                $display("FAIL reset_release edge%0d got %h want %h", e, {ovf_a, sensor_a, q_a}, exp);
            end
        end
        side_road = RED; loop_raw = 1'b0;
    endtask

    task automatic test_glitch();
        do_reset();
        loop_raw = 1'b1;
        tick();
        loop_raw = 1'b0;
        for (int e = 2; e <= 8; e++) begin
            tick();
            vectors++;
            if ({sensor_a, q_a} !== 9'd0) begin
                errors++;
                $display("FAIL glitch edge%0d got %h want %h", e, {sensor_a, q_a}, 9'd0);
            end
        end
    endtask

    task automatic test_arrival();
        logic [8:0] exp;
        do_reset();
        loop_raw = 1'b1;
        for (int e = 0; e <= 3; e++) begin
            tick();
            exp = (e == 3) ? {1'b1, 8'd1} : 9'd0;
            vectors++;
            if ({sensor_a, q_a} !== exp) begin
                errors++;
                $display("FAIL arrival N+%0d got %h want %h", e, {sensor_a, q_a}, exp);
            end
        end
        tick(); tick();
        loop_raw = 1'b0;
        repeat (8) tick();
        vectors++;
        if ({sensor_a, q_a} !== {1'b1, 8'd1}) begin
            errors++;
            $display("FAIL arrival_after_fall got %h want %h", {sensor_a, q_a}, {1'b1, 8'd1});
        end
    endtask

    task automatic test_drain();
        logic [7:0] exp_q [1:9];
        exp_q = '{8'd3, 8'd3, 8'd2, 8'd2, 8'd2, 8'd1, 8'd1, 8'd1, 8'd0};
        do_reset();
        repeat (3) do_arrival();
        vectors++;
        if (q_a !== 8'd3) begin
            errors++;
            $display("FAIL drain_fill got %0d want 3", q_a);
        end
        side_road = GREEN;
        for (int e = 1; e <= 9; e++) begin
            tick();
            vectors++;
            if ({sensor_a, q_a} !== {exp_q[e] != 8'd0, exp_q[e]}) begin
                errors++;
                $display("FAIL drain edge%0d got %h want %h", e, {sensor_a, q_a}, {exp_q[e] != 8'd0, exp_q[e]});
            end
        end
        // Red gap on edge 2 and an illegal code on edge 6 both restart the timer.
        do_reset();
        repeat (2) do_arrival();
        for (int e = 1; e <= 9; e++) begin
            side_road = (e == 2) ? RED : (e == 6) ? 3'b111 : GREEN;
            tick();
            vectors++;
            if (q_a !== ((e >= 9) ? 8'd0 : (e >= 5) ? 8'd1 : 8'd2)) begin
                errors++;
                $display("FAIL drain_gap edge%0d got %0d want %0d", e, q_a,
                         (e >= 9) ? 8'd0 : (e >= 5) ? 8'd1 : 8'd2);
            end
        end
        side_road = RED;
    endtask

    task automatic test_simultaneous();
        do_reset();
        repeat (2) do_arrival();
        loop_raw = 1'b1;
        tick();
        side_road = GREEN;
        for (int e = 2; e <= 4; e++) begin
            tick();
            vectors++;
            if ({sensor_a, q_a} !== {1'b1, 8'd2}) begin
                errors++;
                $display("FAIL simultaneous edge%0d got %h want %h", e, {sensor_a, q_a}, {1'b1, 8'd2});
            end
        end
        side_road = RED;
        loop_raw = 1'b0;
        repeat (8) tick();
        vectors++;
        if ({sensor_a, q_a} !== {1'b1, 8'd2}) begin
            errors++;
            $display("FAIL simultaneous_settle got %h want %h", {sensor_a, q_a}, {1'b1, 8'd2});
        end
    endtask

    task automatic test_saturation();
        do_reset();
        repeat (3) do_arrival();
        vectors++;
        if ({ovf_b, q_b} !== {1'b0, 8'd3}) begin
            errors++;
            $display("FAIL sat_full got %h want %h", {ovf_b, q_b}, {1'b0, 8'd3});
        end
        loop_raw = 1'b1;
        for (int e = 0; e <= 3; e++) begin
            tick();
            vectors++;
            if ({ovf_b, q_b} !== {e == 3, 8'd3}) begin
                errors++;
                $display("FAIL sat_4th N+%0d got %h want %h", e, {ovf_b, q_b}, {e == 3, 8'd3});
            end
        end
        loop_raw = 1'b0;
        repeat (6) tick();
        side_road = GREEN;
        repeat (9) tick();
        side_road = RED;
        tick();
        vectors++;
        if ({ovf_b, sensor_b, q_b} !== {1'b1, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL sat_drained got %h want %h", {ovf_b, sensor_b, q_b}, {1'b1, 1'b0, 8'd0});
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (ovf_b !== 1'b0) begin
            errors++;
            $display("FAIL sat_clear got %b want 0", ovf_b);
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_arrival();
        test_drain();
        test_simultaneous();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/side_sensor.md
SIDE_SENSOR -- requirements
Module: side_sensor

Interface
REQ-001 Parameter DEB_CYCLES, default 2: consecutive synchronized samples required to accept a loop edge; legal range 1-15.
REQ-002 Parameter DEPART_CYCLES, default 3: consecutive side-green cycles per departing vehicle; legal range 1-255.
REQ-003 Parameter QMAX, default 255: queue saturation value; legal range 1-255.
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1: reset, synchronous, active-high.
REQ-006 Port loop_raw, input, 1: asynchronous, bouncy side-road inductive-loop detector; 1 = vehicle over loop.
REQ-007 Port side_road, input, 3: side-road lamp state from the traffic controller; 3'b100 red, 3'b010 yellow, 3'b001 green.
REQ-008 Port SENSOR, output, 1: registered vehicle-waiting request to the traffic controller.
REQ-009 Port queue_cnt, output, 8: registered count of vehicles waiting on the side road.
REQ-010 Port overflow, output, 1: registered sticky flag; arrival lost at saturation.

Function
REQ-011 loop_raw SHALL pass through a two-flop synchronizer; loop_s is the second flop; all other logic uses only loop_s.
REQ-012 Debounce FSM states: IDLE, RISE_CHK, OCCUPIED, FALL_CHK; 4-bit sample counter deb_cnt.
REQ-013 IDLE: loop_s=1 -> RISE_CHK, deb_cnt=1; else stay.
REQ-014 RISE_CHK: loop_s=0 -> IDLE; loop_s=1 and deb_cnt+1 reaches DEB_CYCLES -> OCCUPIED with one-cycle arrival event; else deb_cnt increments. With DEB_CYCLES=1, IDLE goes directly to OCCUPIED with arrival.
REQ-015 OCCUPIED: loop_s=0 -> FALL_CHK, deb_cnt=1; else stay.
REQ-016 FALL_CHK: loop_s=1 -> OCCUPIED, no arrival; loop_s=0 for DEB_CYCLES consecutive samples -> IDLE; no event on departure from the loop.
REQ-017 Latency: loop_raw high and stable, first captured at edge N -> queue_cnt and SENSOR update at edge N+1+DEB_CYCLES.
REQ-018 Loop pulses shorter than DEB_CYCLES synchronized samples SHALL not count.
REQ-019 Departure timer dep_tmr, 8 bits: increments on each edge with side_road==3'b001; at DEPART_CYCLES consecutive green edges, a one-cycle depart event fires and dep_tmr returns to 0.
REQ-020 Any edge with side_road != 3'b001, including the illegal codes, clears dep_tmr with no depart event.
REQ-021 Queue update per edge: arrival only -> +1, saturating at QMAX; depart only -> -1 when queue_cnt>0, else no change.
REQ-022 Arrival and depart on the same edge -> queue_cnt unchanged, including at 0 and at QMAX.
REQ-023 Arrival alone with queue_cnt==QMAX -> queue_cnt holds; overflow=1 and stays 1 until rst.
REQ-024 SENSOR SHALL be registered and updated on the same edge as queue_cnt; SENSOR=1 exactly when the new queue_cnt is nonzero.
REQ-025 Outputs SHALL have no combinational path from any input.

Reset
REQ-026 With rst=1 at an edge: queue_cnt=0, SENSOR=0, overflow=0, FSM=IDLE, deb_cnt=0, dep_tmr=0, synchronizer flops=0.
REQ-027 rst takes priority over all events on the same edge; reset mid-debounce or mid-departure discards partial progress.
REQ-028 After rst deasserts, a loop held high needs the full synchronizer and debounce latency before counting.

Verification
REQ-029 Reset: rst=1 for 2 edges with loop_raw=1 and side_road=3'b001 -> queue_cnt=0, SENSOR=0, overflow=0 throughout; first arrival at edge 4 after release (DEB_CYCLES=2).
REQ-030 Glitch: side_road=3'b100, loop_raw high for 1 cycle -> queue_cnt stays 0 and SENSOR stays 0.
REQ-031 Arrival: side_road=3'b100, loop_raw high for 6 cycles then low, with loop_raw first captured at edge N -> queue_cnt=1 and SENSOR=1 at edge N+3; both unchanged after loop_raw falls.
REQ-032 Drain: queue_cnt=3, side_road=3'b001 for 9 edges -> queue_cnt goes 2, 1, 0 at green edges 3, 6, 9; SENSOR falls at edge 9; a red gap at edge 2 restarts the count.
REQ-033 Simultaneous events: queue_cnt=2, arrival and depart on the same edge -> queue_cnt remains 2 and SENSOR remains 1.
REQ-034 Saturation: QMAX=3, four debounced arrivals with side red -> queue_cnt=3, overflow=1 from the 4th arrival edge; overflow stays 1 after draining to 0 and clears only on rst.
